// File: rtl/ahb_sram_pkg.sv
// Shared AHB-Lite encodings, FSM state codes and byte-strobe helper for the SRAM slave.
package ahb_sram_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_DATA = 3'd1;
  localparam state_t ST_WAIT = 3'd2;
  localparam state_t ST_ERR1 = 3'd3;
  localparam state_t ST_ERR2 = 3'd4;

  // Anything wider than a halfword enables all four lanes.
  function automatic logic [3:0] size_to_strobe(input logic [2:0] hsize, input logic [1:0] addr_lo);
    logic [3:0] s;
    case (hsize)
      HSIZE_BYTE: s = 4'b0001 << addr_lo;
      HSIZE_HALF: s = addr_lo[1] ? 4'b1100 : 4'b0011;
      default:    s = 4'b1111;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/ahb_sram_mem.sv
// Word-wide SRAM: one synchronous read port, one byte-enabled write port, write-first bypass.
module ahb_sram_mem
  import ahb_sram_pkg::*;
#(
  parameter int DEPTH_WORDS = 4096,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [31:0]   o_rdata,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [3:0]    i_wbe,
  input  logic [31:0]   i_wdata
);

  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_rdata;
  logic        w_hit;

  assign w_hit   = i_we && (i_waddr == i_raddr);
  assign o_rdata = r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int b = 0; b < 4; b++)
        if (i_wbe[b]) r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
    end
  end

  // A read colliding with a committing write sees the merged word.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_rdata <= '0;
    else if (i_re) begin
      for (int b = 0; b < 4; b++)
        r_rdata[8*b +: 8] <= (w_hit && i_wbe[b]) ? i_wdata[8*b +: 8] : r_mem[i_raddr][8*b +: 8];
    end
  end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave with optional wait states.
// Define AHB_SRAM_ERR_RESP_EN to flag out-of-range / misaligned transfers with a two-cycle ERROR.
module ahb_sram_slave
  import ahb_sram_pkg::*;
#(
  parameter int DEPTH_WORDS = 4096,
  parameter int WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [31:0] ex_i_ahb_AHB_Slave_RAM_haddr,
  input  logic [2:0]  ex_i_ahb_AHB_Slave_RAM_hburst,
  input  logic        ex_i_ahb_AHB_Slave_RAM_hmastlock,
  input  logic [3:0]  ex_i_ahb_AHB_Slave_RAM_hprot,
  input  logic        ex_i_ahb_AHB_Slave_RAM_hready,
  input  logic        ex_i_ahb_AHB_Slave_RAM_hsel,
  input  logic [2:0]  ex_i_ahb_AHB_Slave_RAM_hsize,
  input  logic [1:0]  ex_i_ahb_AHB_Slave_RAM_htrans,
  input  logic [31:0] ex_i_ahb_AHB_Slave_RAM_hwdata,
  input  logic        ex_i_ahb_AHB_Slave_RAM_hwrite,
  output logic [31:0] ex_i_ahb_AHB_Slave_RAM_hrdata,
  output logic        ex_i_ahb_AHB_Slave_RAM_hready_resp,
  output logic [1:0]  ex_i_ahb_AHB_Slave_RAM_hresp
);

  localparam int         AW = $clog2(DEPTH_WORDS);
  localparam logic [2:0] WS = 3'(WAIT_STATES);

  state_t        r_state;
  logic [2:0]    r_cnt;
  logic [AW-1:0] r_widx;
  logic [1:0]    r_alo;
  logic [2:0]    r_size;
  logic          r_write;

  logic          w_accept, w_illegal, w_re, w_we;
  logic [AW-1:0] w_raddr;
  logic [31:0]   w_rdata;
  logic          w_unused;

  assign w_unused = ^{ex_i_ahb_AHB_Slave_RAM_hburst, ex_i_ahb_AHB_Slave_RAM_hprot,
                      ex_i_ahb_AHB_Slave_RAM_hmastlock, ex_i_ahb_AHB_Slave_RAM_haddr};

  assign w_accept = ex_i_ahb_AHB_Slave_RAM_hsel && ex_i_ahb_AHB_Slave_RAM_hready &&
                    (ex_i_ahb_AHB_Slave_RAM_htrans == HTRANS_NONSEQ ||
                     ex_i_ahb_AHB_Slave_RAM_htrans == HTRANS_SEQ) &&
                    (r_state == ST_IDLE || r_state == ST_DATA || r_state == ST_ERR2);

`ifdef AHB_SRAM_ERR_RESP_EN
  localparam logic [31:0] BYTES = 32'(DEPTH_WORDS) * 32'd4;
  assign w_illegal = (ex_i_ahb_AHB_Slave_RAM_haddr >= BYTES) ||
                     (ex_i_ahb_AHB_Slave_RAM_hsize > HSIZE_WORD) ||
                     (ex_i_ahb_AHB_Slave_RAM_hsize == HSIZE_HALF && ex_i_ahb_AHB_Slave_RAM_haddr[0]) ||
                     (ex_i_ahb_AHB_Slave_RAM_hsize == HSIZE_WORD && ex_i_ahb_AHB_Slave_RAM_haddr[1:0] != 2'b00);
  assign ex_i_ahb_AHB_Slave_RAM_hresp = (r_state == ST_ERR1 || r_state == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
`else
  assign w_illegal = 1'b0;
  assign ex_i_ahb_AHB_Slave_RAM_hresp = HRESP_OKAY;
`endif

  assign ex_i_ahb_AHB_Slave_RAM_hready_resp = !(r_state == ST_WAIT || r_state == ST_ERR1);

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_WAIT: begin
          r_cnt <= r_cnt - 3'd1;
          if (r_cnt <= 3'd1) r_state <= ST_DATA;
        end
        ST_ERR1: r_state <= ST_ERR2;
        default: begin
          if (!w_accept)           r_state <= ST_IDLE;
          else if (w_illegal)      r_state <= ST_ERR1;
          else if (WS == 3'd0)     r_state <= ST_DATA;
          else begin
            r_state <= ST_WAIT;
            r_cnt   <= WS;
          end
        end
      endcase
    end
  end

  always_ff @(posedge HCLK) begin
    if (w_accept) begin
      r_widx  <= ex_i_ahb_AHB_Slave_RAM_haddr[AW+1:2];
      r_alo   <= ex_i_ahb_AHB_Slave_RAM_haddr[1:0];
      r_size  <= ex_i_ahb_AHB_Slave_RAM_hsize;
      r_write <= ex_i_ahb_AHB_Slave_RAM_hwrite;
    end
  end

  // Zero-wait reads launch on the accept edge; otherwise on the edge into DATA.
  generate
    if (WAIT_STATES == 0) begin : g_nows
      assign w_raddr = ex_i_ahb_AHB_Slave_RAM_haddr[AW+1:2];
      assign w_re    = w_accept && !w_illegal && !ex_i_ahb_AHB_Slave_RAM_hwrite;
    end else begin : g_ws
      assign w_raddr = r_widx;
      assign w_re    = (r_state == ST_WAIT) && (r_cnt <= 3'd1) && !r_write;
    end
  endgenerate

  assign w_we = HRESETn && (r_state == ST_DATA) && r_write;

  ahb_sram_mem #(.DEPTH_WORDS(DEPTH_WORDS)) u_mem (
    .i_clk   (HCLK),
    .i_rst_n (HRESETn),
    .i_re    (w_re),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata),
    .i_we    (w_we),
    .i_waddr (r_widx),
    .i_wbe   (size_to_strobe(r_size, r_alo)),
    .i_wdata (ex_i_ahb_AHB_Slave_RAM_hwdata)
  );

  assign ex_i_ahb_AHB_Slave_RAM_hrdata = w_rdata;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: two instances (0 and 3 wait states, 16 words) vs a word-array model.
// Honours AHB_SRAM_ERR_RESP_EN for the expected error behaviour.
module tb_ahb_sram_slave;

  localparam int DEPTH = 16;
  localparam int NT    = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst_n;
  logic [1:0][31:0] haddr, hwdata, hrdata;
  logic [1:0][2:0]  hsize;
  logic [1:0][1:0]  htrans, hresp;
  logic [1:0]       hsel, hwrite, hready_resp;

  ahb_sram_slave #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) u_dut0 (
    .HCLK(clk), .HRESETn(rst_n[0]),
    .ex_i_ahb_AHB_Slave_RAM_haddr(haddr[0]), .ex_i_ahb_AHB_Slave_RAM_hburst(3'd0),
    .ex_i_ahb_AHB_Slave_RAM_hmastlock(1'b0), .ex_i_ahb_AHB_Slave_RAM_hprot(4'd0),
    .ex_i_ahb_AHB_Slave_RAM_hready(hready_resp[0]), .ex_i_ahb_AHB_Slave_RAM_hsel(hsel[0]),
    .ex_i_ahb_AHB_Slave_RAM_hsize(hsize[0]), .ex_i_ahb_AHB_Slave_RAM_htrans(htrans[0]),
    .ex_i_ahb_AHB_Slave_RAM_hwdata(hwdata[0]), .ex_i_ahb_AHB_Slave_RAM_hwrite(hwrite[0]),
    .ex_i_ahb_AHB_Slave_RAM_hrdata(hrdata[0]), .ex_i_ahb_AHB_Slave_RAM_hready_resp(hready_resp[0]),
    .ex_i_ahb_AHB_Slave_RAM_hresp(hresp[0]));

  ahb_sram_slave #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(3)) u_dut3 (
    .HCLK(clk), .HRESETn(rst_n[1]),
    .ex_i_ahb_AHB_Slave_RAM_haddr(haddr[1]), .ex_i_ahb_AHB_Slave_RAM_hburst(3'd0),
    .ex_i_ahb_AHB_Slave_RAM_hmastlock(1'b0), .ex_i_ahb_AHB_Slave_RAM_hprot(4'd0),
    .ex_i_ahb_AHB_Slave_RAM_hready(hready_resp[1]), .ex_i_ahb_AHB_Slave_RAM_hsel(hsel[1]),
    .ex_i_ahb_AHB_Slave_RAM_hsize(hsize[1]), .ex_i_ahb_AHB_Slave_RAM_htrans(htrans[1]),
    .ex_i_ahb_AHB_Slave_RAM_hwdata(hwdata[1]), .ex_i_ahb_AHB_Slave_RAM_hwrite(hwrite[1]),
    .ex_i_ahb_AHB_Slave_RAM_hrdata(hrdata[1]), .ex_i_ahb_AHB_Slave_RAM_hready_resp(hready_resp[1]),
    .ex_i_ahb_AHB_Slave_RAM_hresp(hresp[1]));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", tag, act, exp);
    end
  endtask

  // Transfer list and per-transfer observations
  int          n_tr;
  bit          tr_write [NT];
  int          tr_addr  [NT];
  int          tr_size  [NT];
  logic [31:0] tr_wdata [NT];
  logic [31:0] res_rdata[NT];
  int          res_waits[NT];
  bit          res_err  [NT];
  bit          res_errlo[NT];

  // Reference model
  logic [31:0] mm [2][DEPTH];
  logic [31:0] last_rd [2];

  function automatic int ws_of(input int k);
    return (k == 0) ? 0 : 3;
  endfunction

  function automatic bit legal(input int a, input int sz);
`ifdef AHB_SRAM_ERR_RESP_EN
    return (a < DEPTH * 4) && (sz <= 2) && !(sz == 1 && a % 2 != 0) && !(sz == 2 && a % 4 != 0);
`else
    return 1'b1;
`endif
  endfunction

  function automatic bit lane_hit(input int b, input int sz, input int a);
    if (sz == 0) return b == a % 4;
    if (sz == 1) return b / 2 == (a % 4) / 2;
    return 1'b1;
  endfunction

  task automatic add(input bit w, input int a, input int sz, input logic [31:0] d);
    tr_write[n_tr] = w; tr_addr[n_tr] = a; tr_size[n_tr] = sz; tr_wdata[n_tr] = d;
    n_tr++;
  endtask

  task automatic drive_idle(input int k);
    hsel[k] = 1'b0; htrans[k] = 2'b00; hwrite[k] = 1'b0; haddr[k] = '0; hsize[k] = '0;
  endtask

  task automatic evaluate(input int k);
    for (int i = 0; i < n_tr; i++) begin
      bit leg;
      int widx;
      leg  = legal(tr_addr[i], tr_size[i]);
      widx = (tr_addr[i] / 4) % DEPTH;
      chk($sformatf("k%0d t%0d waits", k, i), res_waits[i], leg ? ws_of(k) : 1);
      chk($sformatf("k%0d t%0d err", k, i), res_err[i], !leg);
      chk($sformatf("k%0d t%0d errlo", k, i), res_errlo[i], !leg);
      if (leg) begin
        if (tr_write[i]) begin
          for (int b = 0; b < 4; b++)
            if (lane_hit(b, tr_size[i], tr_addr[i])) mm[k][widx][8*b +: 8] = tr_wdata[i][8*b +: 8];
        end else last_rd[k] = mm[k][widx];
      end
      chk($sformatf("k%0d t%0d hrdata", k, i), res_rdata[i], last_rd[k]);
    end
  endtask

  // Pipelined master: address phase of the next transfer overlaps the current data phase.
  task automatic run(input int k);
    int a, d, guard;
    logic rdy;
    a = 0; d = -1; guard = 0;
    for (int i = 0; i < n_tr; i++) begin res_waits[i] = 0; res_errlo[i] = 0; res_err[i] = 0; end
    while ((a < n_tr || d >= 0) && guard < 400) begin
      @(negedge clk);
      guard++;
      rdy = hready_resp[k];
      if (d >= 0) begin
        if (rdy) begin
          res_rdata[d] = hrdata[k];
          res_err[d]   = (hresp[k] == 2'b01);
        end else begin
          res_waits[d]++;
          if (hresp[k] == 2'b01) res_errlo[d] = 1'b1;
        end
      end
      hwdata[k] = (d >= 0) ? tr_wdata[d] : 32'h0;
      if (a < n_tr) begin
        hsel[k] = 1'b1; htrans[k] = 2'b10; haddr[k] = 32'(tr_addr[a]);
        hwrite[k] = tr_write[a]; hsize[k] = 3'(tr_size[a]);
      end else drive_idle(k);
      if (rdy) begin
        d = (a < n_tr) ? a : -1;
        if (a < n_tr) a++;
      end
    end
    @(negedge clk);
    drive_idle(k);
    if (guard >= 400) chk($sformatf("k%0d timeout", k), 32'(guard), 32'd0);
    evaluate(k);
    n_tr = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] old0;
    n_tr = 0;
    rst_n = 2'b00;
    hwdata = '0;
    for (int k = 0; k < 2; k++) begin drive_idle(k); last_rd[k] = '0; end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("k%0d rst hready", k), 32'(hready_resp[k]), 32'd1);
      chk($sformatf("k%0d rst hresp", k), 32'(hresp[k]), 32'd0);
      chk($sformatf("k%0d rst hrdata", k), hrdata[k], 32'h0);
    end
    rst_n = 2'b11;

    for (int k = 0; k < 2; k++) begin
      for (int w = 0; w < DEPTH; w++) add(1'b1, w * 4, 2, $urandom);
      run(k);

      add(1'b1, 'h10, 2, 32'hDEADBEEF); run(k);
      add(1'b0, 'h10, 2, 32'h0);        run(k);
      chk($sformatf("k%0d deadbeef", k), res_rdata[0], 32'hDEADBEEF);

      add(1'b1, 'h10, 2, 32'h11223344);
      add(1'b1, 'h13, 0, 32'hAA000000);
      add(1'b0, 'h10, 2, 32'h0);
      run(k);
      chk($sformatf("k%0d byte merge", k), res_rdata[2], 32'hAA223344);
      add(1'b1, 'h10, 1, 32'h00005566);
      add(1'b0, 'h10, 2, 32'h0);
      run(k);
      chk($sformatf("k%0d half merge", k), res_rdata[1], 32'hAA225566);

      add(1'b1, 'h20, 2, 32'h12345678);
      add(1'b0, 'h20, 2, 32'h0);
      run(k);
      chk($sformatf("k%0d bypass", k), res_rdata[1], 32'h12345678);

      old0 = mm[k][0];
      add(1'b1, 'h40, 2, 32'h0BADF00D);
      add(1'b0, 'h00, 2, 32'h0);
      run(k);
`ifdef AHB_SRAM_ERR_RESP_EN
      chk($sformatf("k%0d oob unchanged", k), res_rdata[1], old0);
`else
      chk($sformatf("k%0d oob wrap", k), res_rdata[1], 32'h0BADF00D);
`endif

      for (int i = 0; i < 40; i++)
        add($urandom_range(0, 1), $urandom_range(0, 79), $urandom_range(0, 3), $urandom);
      run(k);
    end

    // Reset during the wait phase of a write must drop the write.
    @(negedge clk);
    hsel[1] = 1'b1; htrans[1] = 2'b10; haddr[1] = 32'h08; hwrite[1] = 1'b1; hsize[1] = 3'd2;
    @(negedge clk);
    drive_idle(1);
    hwdata[1] = 32'hCAFEF00D;
    chk("rst-in-wait hready low", 32'(hready_resp[1]), 32'd0);
    rst_n[1] = 1'b0;
    @(negedge clk);
    rst_n[1] = 1'b1;
    chk("rst-in-wait hready", 32'(hready_resp[1]), 32'd1);
    chk("rst-in-wait hresp", 32'(hresp[1]), 32'd0);
    chk("rst-in-wait hrdata", hrdata[1], 32'h0);
    last_rd[1] = '0;
    add(1'b0, 'h08, 2, 32'h0);
    run(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
